// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port: access sizes and requester ownership.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package mem_port_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Number of bytes touched by an access; the reserved code is sized as a word
  // so the range check stays meaningful, it is flagged as an error separately.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_align_check.sv
// Flags a data access that is misaligned, uses the reserved size or leaves the memory window.
// Latency: purely combinational.
// Backpressure: none; the result is valid whenever addr_i/size_i are.
module mem_align_check
  import mem_port_arbiter_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h0100_0000,
  parameter logic [31:0] MEM_SIZE   = 32'd1048576
) (
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  output logic        err_o
);

  // 33-bit bounds so an access at the very top of the address space cannot wrap
  localparam logic [32:0] LO_ADDR = {1'b0, START_ADDR};
  localparam logic [32:0] HI_ADDR = {1'b0, START_ADDR} + {1'b0, MEM_SIZE};

  logic [32:0] last_byte;
  logic        misaligned;
  logic        out_of_range;
  logic        bad_size;

  // Alignment, reserved-size and window checks on the first and last byte touched
  always_comb begin
    last_byte    = {1'b0, addr_i} + {30'd0, size_bytes(size_i)} - 33'd1;
    bad_size     = (size_i == SZ_RSVD);
    misaligned   = 1'b0;
    if (size_i == SZ_HALF) begin
      misaligned = addr_i[0];
    end else if (size_i == SZ_WORD) begin
      misaligned = |addr_i[1:0];
    end
    out_of_range = ({1'b0, addr_i} < LO_ADDR) || (last_byte >= HI_ADDR);
    err_o        = bad_size || misaligned || out_of_range;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; D wins unless its streak is exhausted.
// Latency: grant is combinational, rvalid/rdata/err are registered one cycle after the grant.
// Backpressure: requesters hold requests until gnt; responses cannot be stalled.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter logic [31:0] START_ADDR   = 32'h0100_0000,
  parameter logic [31:0] MEM_SIZE     = 32'd1048576
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_rdun,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_w_enable,
  output logic [1:0]  mem_access_size,
  output logic        mem_rdun,
  input  logic [31:0] mem_data_out
);

  localparam int unsigned         STREAK_W   = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  owner_e              owner;
  logic                d_err_c;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                if_rvalid_q, d_rvalid_q, d_err_q;
  logic [31:0]         if_rdata_q, d_rdata_q;

  mem_align_check #(
    .START_ADDR (START_ADDR),
    .MEM_SIZE   (MEM_SIZE)
  ) u_align_check (
    .addr_i (d_addr),
    .size_i (d_size),
    .err_o  (d_err_c)
  );

  // Data-over-fetch priority; fetch wins once D has taken MAX_D_STREAK grants in a row
  always_comb begin
    owner = OWN_NONE;
    if (d_req && !(if_req && (streak_q == STREAK_MAX))) begin
      owner = OWN_D;
    end else if (if_req) begin
      owner = OWN_IF;
    end
  end

  // Streak counts D grants only while fetch is waiting, saturating at the limit
  always_comb begin
    streak_d = streak_q;
    if (!if_req || (owner == OWN_IF)) begin
      streak_d = '0;
    end else if ((owner == OWN_D) && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  assign if_gnt = (owner == OWN_IF);
  assign d_gnt  = (owner == OWN_D);

  // Memory port mux; idle cycles park on the fetch address with writes disabled
  always_comb begin
    mem_address     = if_addr;
    mem_data_in     = '0;
    mem_w_enable    = 1'b0;
    mem_access_size = SZ_WORD;
    mem_rdun        = 1'b0;
    if (owner == OWN_D) begin
      mem_address     = d_addr;
      mem_data_in     = d_wdata;
      mem_w_enable    = reset_n && d_we && !d_err_c;
      mem_access_size = d_size;
      mem_rdun        = d_rdun;
    end else if (owner == OWN_IF) begin
      mem_rdun        = 1'b1;
    end
  end

  // Streak and per-requester response registers; rdata holds until its owner's next capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak_q    <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      streak_q    <= streak_d;
      if_rvalid_q <= (owner == OWN_IF);
      d_rvalid_q  <= (owner == OWN_D);
      d_err_q     <= (owner == OWN_D) && d_err_c;
      if (owner == OWN_IF) begin
        if_rdata_q <= mem_data_out;
      end
      if (owner == OWN_D) begin
        d_rdata_q <= (d_err_c || d_we) ? 32'd0 : mem_data_out;
      end
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter with a byte-array memory and a reference model.
// Latency: expects each response exactly one cycle after its grant.
// Backpressure: requests are held until granted, as the core would.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int          MAXS  = 4;
  localparam logic [31:0] START = 32'h0100_0000;
  localparam logic [31:0] MSIZE = 32'd1048576;
  localparam int          WIN   = 1024;

  logic        clk;
  logic        reset_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_rdun, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_size;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_w_enable, mem_rdun;
  logic [1:0]  mem_access_size;

  mem_port_arbiter #(
    .MAX_D_STREAK (MAXS),
    .START_ADDR   (START),
    .MEM_SIZE     (MSIZE)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .if_req          (if_req),
    .if_addr         (if_addr),
    .if_gnt          (if_gnt),
    .if_rvalid       (if_rvalid),
    .if_rdata        (if_rdata),
    .d_req           (d_req),
    .d_we            (d_we),
    .d_addr          (d_addr),
    .d_wdata         (d_wdata),
    .d_size          (d_size),
    .d_rdun          (d_rdun),
    .d_gnt           (d_gnt),
    .d_rvalid        (d_rvalid),
    .d_rdata         (d_rdata),
    .d_err           (d_err),
    .mem_address     (mem_address),
    .mem_data_in     (mem_data_in),
    .mem_w_enable    (mem_w_enable),
    .mem_access_size (mem_access_size),
    .mem_rdun        (mem_rdun),
    .mem_data_out    (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
  endtask

  // ---------------- environment helpers ----------------
  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 73 + 11) ^ (i >> 3));
  endfunction

  function automatic logic [9:0] widx(input logic [31:0] a);
    return 10'(a - START);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    if (sz == SZ_BYTE) return 1;
    if (sz == SZ_HALF) return 2;
    return 4;
  endfunction

  // Error rule from first principles: bad size, misalignment, or any byte outside the window
  function automatic bit ref_err(input logic [31:0] a, input logic [1:0] sz);
    longint lo, hi_excl;
    if (sz == 2'b11) return 1'b1;
    if (sz == SZ_HALF && (a % 2) != 0) return 1'b1;
    if (sz == SZ_WORD && (a % 4) != 0) return 1'b1;
    lo      = longint'(a);
    hi_excl = longint'(START) + longint'(MSIZE);
    if (lo < longint'(START) || lo + nbytes(sz) - 1 >= hi_excl) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- memory (aliased 1 KiB window) ----------------
  logic [7:0]  mem [WIN];
  logic [31:0] rd_word;
  int          stray_writes = 0;

  initial begin
    for (int i = 0; i < WIN; i++) mem[i] = init_byte(i);
    forever begin
      @(posedge clk);
      if (mem_w_enable) begin
        if (ref_err(mem_address, mem_access_size)) stray_writes++;
        else for (int k = 0; k < nbytes(mem_access_size); k++)
          mem[widx(mem_address + 32'(k))] = mem_data_in[8*k +: 8];
      end
    end
  end

  always_comb begin
    rd_word = {mem[widx(mem_address + 32'd3)], mem[widx(mem_address + 32'd2)],
               mem[widx(mem_address + 32'd1)], mem[widx(mem_address)]};
    case (mem_access_size)
      SZ_BYTE: mem_data_out = mem_rdun ? {24'd0, rd_word[7:0]}   : {{24{rd_word[7]}}, rd_word[7:0]};
      SZ_HALF: mem_data_out = mem_rdun ? {16'd0, rd_word[15:0]}  : {{16{rd_word[15]}}, rd_word[15:0]};
      default: mem_data_out = rd_word;
    endcase
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic        err;
    logic [31:0] data;
    int          gcyc;
  } rsp_t;

  rsp_t        if_q[$];
  rsp_t        d_q[$];
  logic [7:0]  ref_mem [WIN];
  int          m_streak;
  bit          if_gseen, d_gseen, log_en;
  int          glog[$];
  bit          exp_d, exp_if, e_err;
  rsp_t        e_new, m_if, m_d;

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = 32'd0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[widx(a + 32'(k))];
    if (!uns && n < 4 && v[8*n-1]) for (int b = 8 * n; b < 32; b++) v[b] = 1'b1;
    return v;
  endfunction

  // Observer: checks arbitration against the priority rule and queues expected responses
  initial begin
    m_streak = 0;
    for (int i = 0; i < WIN; i++) ref_mem[i] = init_byte(i);
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_streak = 0;
        if_gseen = 1'b0;
        d_gseen  = 1'b0;
      end else begin
        exp_d  = d_req && !(if_req && m_streak == MAXS);
        exp_if = if_req && !exp_d;
        check("d_gnt", 32'(d_gnt), 32'(exp_d));
        check("if_gnt", 32'(if_gnt), 32'(exp_if));
        if (log_en) glog.push_back(d_gnt ? 2 : (if_gnt ? 1 : 0));
        e_new.gcyc = cyc;
        if (d_gnt) begin
          e_err = ref_err(d_addr, d_size);
          check("d_mem_address", mem_address, d_addr);
          check("d_mem_w_enable", 32'(mem_w_enable), 32'(d_we && !e_err));
          e_new.err  = e_err;
          e_new.data = (e_err || d_we) ? 32'd0 : ref_load(d_addr, d_size, d_rdun);
          if (d_we && !e_err)
            for (int k = 0; k < nbytes(d_size); k++) ref_mem[widx(d_addr + 32'(k))] = d_wdata[8*k +: 8];
          d_q.push_back(e_new);
        end else if (if_gnt) begin
          check("if_mem_address", mem_address, if_addr);
          check("if_mem_w_enable", 32'(mem_w_enable), 32'd0);
          e_new.err  = 1'b0;
          e_new.data = ref_load(if_addr, SZ_WORD, 1'b1);
          if_q.push_back(e_new);
        end else begin
          check("idle_mem_w_enable", 32'(mem_w_enable), 32'd0);
          check("idle_mem_size", 32'(mem_access_size), 32'(SZ_WORD));
        end
        if (if_req && d_gnt) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
        else m_streak = 0;
        if_gseen = if_gnt;
        d_gseen  = d_gnt;
      end
    end
  end

  // Monitor: every response pops its expectation and must land exactly one cycle after the grant
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (if_rvalid) begin
          if (if_q.size() == 0) check("if_rvalid_without_grant", 32'(if_rvalid), 32'd0);
          else begin
            m_if = if_q.pop_front();
            check("if_latency", cyc, m_if.gcyc + 1);
            check("if_rdata", if_rdata, m_if.data);
          end
        end
        if (d_rvalid) begin
          if (d_q.size() == 0) check("d_rvalid_without_grant", 32'(d_rvalid), 32'd0);
          else begin
            m_d = d_q.pop_front();
            check("d_latency", cyc, m_d.gcyc + 1);
            check("d_err", 32'(d_err), 32'(m_d.err));
            check("d_rdata", d_rdata, m_d.data);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_gnt(input string name, input bit is_d);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = is_d ? d_gnt : if_gnt;
    end
    check({name, "_granted"}, 32'(got), 32'd1);
  endtask

  task automatic d_op(input string name, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic uns, input logic exp_err, output logic [31:0] rdata);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_size = size; d_rdun = uns;
    wait_gnt(name, 1'b1);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    check({name, "_rvalid"}, 32'(d_rvalid), 32'd1);
    check({name, "_err"}, 32'(d_err), 32'(exp_err));
    rdata = d_rdata;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_d_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)  return START + 32'($urandom_range(0, WIN - 1));
    if (r == 7) return START + MSIZE - 32'($urandom_range(1, 4));
    if (r == 8) return START - 32'($urandom_range(1, 4));
    return START + MSIZE + 32'($urandom_range(0, 8));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog timeout");
  end

  logic [31:0] rd;
  int          cnt;
  int unsigned sel;

  initial begin
    // Reset held with a store pending: nothing may be written or reported
    reset_n = 1'b0; log_en = 1'b0;
    if_req = 1'b0; if_addr = START;
    d_req = 1'b1; d_we = 1'b1; d_addr = START + 32'h8; d_wdata = 32'h1122_3344; d_size = SZ_WORD; d_rdun = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_w_enable", 32'(mem_w_enable), 32'd0);
    check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rst_d_err", 32'(d_err), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_no_write", 32'(mem[8]), 32'(init_byte(8)));
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1 check("rst_release_d_gnt", 32'(d_gnt), 32'd1);
    @(negedge clk);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;

    // Fetch stream: one grant per cycle, data one cycle later
    if_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if_addr = START + 32'(4 * i);
      wait_gnt("fetch", 1'b0);
      @(posedge clk); #1;
    end
    if_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Store then signed / unsigned loads
    d_op("sb", 1'b1, START + 32'h13, 32'h0000_00A5, SZ_BYTE, 1'b0, 1'b0, rd);
    d_op("lb", 1'b0, START + 32'h13, 32'd0, SZ_BYTE, 1'b0, 1'b0, rd);
    check("lb_data", rd, 32'hFFFF_FFA5);
    d_op("lbu", 1'b0, START + 32'h13, 32'd0, SZ_BYTE, 1'b1, 1'b0, rd);
    check("lbu_data", rd, 32'h0000_00A5);
    d_op("sh", 1'b1, START + 32'h40, 32'h1234_BEEF, SZ_HALF, 1'b0, 1'b0, rd);
    d_op("lh", 1'b0, START + 32'h40, 32'd0, SZ_HALF, 1'b0, 1'b0, rd);
    check("lh_data", rd, 32'hFFFF_BEEF);
    d_op("lhu", 1'b0, START + 32'h40, 32'd0, SZ_HALF, 1'b1, 1'b0, rd);
    check("lhu_data", rd, 32'h0000_BEEF);

    // Errors and window boundaries
    d_op("lw_mis", 1'b0, START + 32'h2, 32'd0, SZ_WORD, 1'b0, 1'b1, rd);
    check("lw_mis_data", rd, 32'd0);
    d_op("sh_oor", 1'b1, 32'h0110_0000, 32'h0000_CAFE, SZ_HALF, 1'b0, 1'b1, rd);
    d_op("sw_mis", 1'b1, START + 32'h21, 32'hDEAD_BEEF, SZ_WORD, 1'b0, 1'b1, rd);
    for (int k = 0; k < 4; k++) check("sw_mis_mem_unchanged", 32'(mem[8'h21 + k]), 32'(init_byte(32'h21 + k)));
    d_op("size3", 1'b0, START + 32'h10, 32'd0, 2'b11, 1'b0, 1'b1, rd);
    d_op("lb_below", 1'b0, START - 32'd1, 32'd0, SZ_BYTE, 1'b0, 1'b1, rd);
    d_op("lb_top", 1'b0, START + MSIZE - 32'd1, 32'd0, SZ_BYTE, 1'b1, 1'b0, rd);
    d_op("lhu_top", 1'b0, START + MSIZE - 32'd2, 32'd0, SZ_HALF, 1'b1, 1'b0, rd);
    d_op("lw_top", 1'b0, START + MSIZE - 32'd4, 32'd0, SZ_WORD, 1'b0, 1'b0, rd);
    d_op("lw_over", 1'b0, START + MSIZE, 32'd0, SZ_WORD, 1'b0, 1'b1, rd);
    check("no_stray_writes_err", stray_writes, 0);

    // Contention with both requesters held: D,D,D,D,IF repeating
    if_addr = START + 32'h80; d_we = 1'b0; d_addr = START + 32'h84; d_size = SZ_WORD; d_rdun = 1'b0;
    glog.delete();
    if_req = 1'b1; d_req = 1'b1; log_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    log_en = 1'b0; if_req = 1'b0; d_req = 1'b0;
    check("contention_len", glog.size(), 10);
    for (int i = 0; i < glog.size() && i < 10; i++) check("contention_order", glog[i], (i % 5 == 4) ? 1 : 2);
    repeat (2) @(posedge clk);
    #1;

    // Randomised traffic on both ports
    for (int c = 0; c < 500; c++) begin
      if (!if_req || if_gseen) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = START + 32'(4 * $urandom_range(0, WIN / 4 - 1));
      end
      if (!d_req || d_gseen) begin
        d_req   = ($urandom_range(0, 99) < 60);
        d_we    = 1'($urandom_range(0, 1));
        sel     = $urandom_range(0, 9);
        d_size  = (sel < 3) ? SZ_BYTE : (sel < 6) ? SZ_HALF : (sel < 9) ? SZ_WORD : 2'b11;
        d_rdun  = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
        d_addr  = rand_d_addr();
      end
      @(posedge clk); #1;
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("if_q_drained", if_q.size(), 0);
    check("d_q_drained", d_q.size(), 0);

    // Reset during the response cycle drops the response for good
    d_we = 1'b0; d_addr = START + 32'h40; d_size = SZ_WORD; d_req = 1'b1;
    wait_gnt("midrst", 1'b1);
    @(posedge clk); #1;
    d_req = 1'b0;
    reset_n = 1'b0;
    if_q.delete();
    d_q.delete();
    #1 check("midrst_d_rvalid_cleared", 32'(d_rvalid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (d_rvalid) cnt++;
    end
    check("midrst_no_rvalid_after_release", cnt, 0);
    check("no_stray_writes", stray_writes, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
